instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Boot-time program loader. It is the producer side of the instruction path that the decoder consumes.
- Accepts a byte stream from the UART receiver: a 4-byte little-endian word-count header, then that many 32-bit instructions, each little-endian.
- Writes each assembled instruction into instruction memory at consecutive word addresses starting at 0.
- Raises `loaded` to release the CPU core from hold once the whole program is in memory.

Parameters:
- ADDR_WIDTH, default 10: instruction memory word-address width. Capacity DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reload  in  1  synchronous request to restart loading (sampled in every state).
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data holds a valid byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at a rising edge.
- imem_wren  out  1  instruction memory write strobe, one cycle per word.
- imem_address  out  ADDR_WIDTH  word address of the write.
- imem_write_data  out  32  instruction word to write.
- loaded  out  1  program fully written; CPU may run.
- load_error  out  1  header count exceeded DEPTH.

Behaviour:
- Reset (async, rst=1), all outputs registered:
  - State = HEADER; byte_idx = 0; word_idx = 0; word_count = 0.
  - rx_ready = 0 while rst is high, rx_ready = 1 from the first edge after rst deasserts.
  - imem_wren = 0; imem_address = 0; imem_write_data = 0; loaded = 0; load_error = 0.
- States: HEADER, PAYLOAD, FLUSH, DONE, ERROR.
- Byte assembly (HEADER and PAYLOAD):
  - Each accepted byte shifts in little-endian: byte_idx 0 goes to bits [7:0], 3 goes to [31:24].
  - byte_idx is 2 bits and wraps 3 -> 0 on the 4th accepted byte.
  - A cycle with rx_valid=0 holds all state; gaps between bytes are allowed at any point.
- HEADER:
  - rx_ready = 1.
  - On the 4th byte, word_count = assembled 32-bit value, evaluated as unsigned 32-bit.
  - count == 0 -> DONE next cycle.
  - count > DEPTH -> ERROR.
  - Otherwise -> PAYLOAD.
  - count == DEPTH is legal.
- PAYLOAD:
  - rx_ready = 1.
  - On the 4th byte of a word, the cycle after acceptance: imem_wren = 1 for exactly one cycle, imem_address = word_idx, imem_write_data = assembled word.
  - word_idx then increments.
  - The next word's bytes may be accepted in the same cycle as the write strobe; full throughput is one byte per cycle.
  - When the accepted word is word number word_count-1, go to FLUSH instead. rx_ready = 0 from that edge onward.
- FLUSH:
  - The final write strobe is asserted in this cycle, then -> DONE.
  - loaded rises the cycle after the final imem_wren, never in the same cycle.
- DONE:
  - loaded = 1, rx_ready = 0, imem_wren = 0.
  - Extra bytes are not accepted; they remain upstream.
- ERROR:
  - load_error = 1, rx_ready = 0, loaded = 0, no memory writes.
- imem_address / imem_write_data hold their last written values when imem_wren = 0.
- word_idx never wraps: the header bound check guarantees word_idx <= DEPTH-1 at any write.
- reload = 1 in any state:
  - Next state = HEADER; byte_idx, word_idx and word_count cleared; loaded = 0, load_error = 0, imem_wren = 0.
  - reload has priority over a simultaneous byte transfer, which is discarded. rx_ready is driven 0 during any cycle where reload = 1.
  - reload mid-PAYLOAD aborts; words already written are left in memory.
- rst mid-operation: immediate asynchronous return to the reset values. Any in-flight write strobe is dropped.

Test Plan:
- Nominal load: header 02 00 00 00, then bytes 93 00 10 00 / 13 01 20 00 back-to-back -> imem_wren pulses writing addr 0 = 0x00100093 and addr 1 = 0x00200113; loaded = 1 exactly one cycle after the second strobe; rx_ready = 0 from then on.
- Gapped input: same stream with rx_valid toggled 1/0 every cycle -> identical memory contents and order; no strobe on idle cycles.
- Boundaries (ADDR_WIDTH = 2):
  - header 00 00 00 00 -> loaded = 1 after 1 cycle, zero writes.
  - header 04 00 00 00 + 16 bytes -> four writes at addrs 0..3, then loaded = 1.
  - header 05 00 00 00 -> load_error = 1, rx_ready = 0, no writes.
- Reload and back-pressure: reload asserted in the cycle the 3rd payload byte is valid -> byte discarded, state HEADER; a fresh header 01 00 00 00 + EF BE AD DE -> addr 0 = 0xDEADBEEF, loaded = 1. In DONE, rx_valid held high -> rx_ready stays 0 and there is no strobe.
- Async reset mid-PAYLOAD: rst pulsed between clock edges after 2 payload bytes -> all outputs drop to reset values immediately, with no strobe on the next edge; the stream restarts with a header.

Source files
------------

// File: rtl/instruction_loader.sv
// Boot-time program loader: assembles a little-endian byte stream (word-count header,
// then 32-bit instructions) into instruction-memory writes and releases the core when done.
module instruction_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_reload,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic                  o_imem_wren,
    output logic [ADDR_WIDTH-1:0] o_imem_address,
    output logic [31:0]           o_imem_write_data,
    output logic                  o_loaded,
    output logic                  o_load_error
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HEADER,
        S_PAYLOAD,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic [1:0]            r_byte_idx;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [31:0]           r_word_count;
    logic [23:0]           r_shift;
    logic                  r_rx_ready;
    logic                  r_wren;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic                  r_loaded;
    logic                  r_error;

    logic                  w_accept;
    logic [31:0]           w_word;
    logic                  w_last;
    logic                  w_word_done;

    // Only the first three bytes need storage; the fourth is taken straight off the bus.
    function automatic logic [23:0] shift_in(input logic [23:0] shift,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
        logic [23:0] res;
        res = shift;
        case (idx)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            default: res        = shift;
        endcase
        return res;
    endfunction

    // reload wins over a simultaneous transfer, so the handshake is masked by it.
    assign o_rx_ready  = r_rx_ready && !i_reload;
    assign w_accept    = i_rx_valid && o_rx_ready;
    assign w_word      = {i_rx_data, r_shift};
    assign w_word_done = w_accept && (r_byte_idx == 2'd3);
    assign w_last      = (32'(r_word_idx) == (r_word_count - 32'd1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_HEADER;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= '0;
            r_word_count <= 32'd0;
            r_shift      <= 24'd0;
            r_rx_ready   <= 1'b0;
            r_wren       <= 1'b0;
            r_addr       <= '0;
            r_data       <= 32'd0;
            r_loaded     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            if (i_reload) begin
                r_state      <= S_HEADER;
                r_byte_idx   <= 2'd0;
                r_word_idx   <= '0;
                r_word_count <= 32'd0;
                r_shift      <= 24'd0;
                r_rx_ready   <= 1'b1;
                r_loaded     <= 1'b0;
                r_error      <= 1'b0;
            end else begin
                case (r_state)
                    S_HEADER: begin
                        r_rx_ready <= 1'b1;
                        if (w_accept) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= shift_in(r_shift, r_byte_idx, i_rx_data);
                        end
                        if (w_word_done) begin
                            r_word_count <= w_word;
                            if (w_word == 32'd0) begin
                                r_state    <= S_DONE;
                                r_loaded   <= 1'b1;
                                r_rx_ready <= 1'b0;
                            end else if ({1'b0, w_word} > DEPTH) begin
                                r_state    <= S_ERROR;
                                r_error    <= 1'b1;
                                r_rx_ready <= 1'b0;
                            end else begin
                                r_state <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_accept) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= shift_in(r_shift, r_byte_idx, i_rx_data);
                        end
                        if (w_word_done) begin
                            r_wren     <= 1'b1;
                            r_addr     <= r_word_idx;
                            r_data     <= w_word;
                            r_word_idx <= r_word_idx + 1'b1;
                            if (w_last) begin
                                r_state    <= S_FLUSH;
                                r_rx_ready <= 1'b0;
                            end
                        end
                    end
                    // Final strobe is visible during this state; loaded follows one cycle later.
                    S_FLUSH: begin
                        r_rx_ready <= 1'b0;
                        r_state    <= S_DONE;
                        r_loaded   <= 1'b1;
                    end
                    S_DONE: begin
                        r_rx_ready <= 1'b0;
                        r_loaded   <= 1'b1;
                    end
                    S_ERROR: begin
                        r_rx_ready <= 1'b0;
                        r_error    <= 1'b1;
                    end
                    default: begin
                        r_state <= S_HEADER;
                    end
                endcase
            end
        end
    end

    assign o_imem_wren       = r_wren;
    assign o_imem_address    = r_addr;
    assign o_imem_write_data = r_data;
    assign o_loaded          = r_loaded;
    assign o_load_error      = r_error;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader at ADDR_WIDTH=2: the driver queues expected
// memory writes per program, an independent monitor checks every strobe against them.
module tb_instruction_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          reload;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          o_rx_ready;
    logic          o_imem_wren;
    logic [AW-1:0] o_imem_address;
    logic [31:0]   o_imem_write_data;
    logic          o_loaded;
    logic          o_load_error;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] prog_words[0:7];
    logic        exp_final_wren;
    int          checks;
    int          errors;

    instruction_loader #(.ADDR_WIDTH(AW)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_reload          (reload),
        .i_rx_data         (rx_data),
        .i_rx_valid        (rx_valid),
        .o_rx_ready        (o_rx_ready),
        .o_imem_wren       (o_imem_wren),
        .o_imem_address    (o_imem_address),
        .o_imem_write_data (o_imem_write_data),
        .o_loaded          (o_loaded),
        .o_load_error      (o_load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per strobe, and checks loaded follows the final strobe.
    initial begin : monitor
        logic prev_wren;
        logic prev_loaded;
        wr_t  e;
        prev_wren   = 1'b0;
        prev_loaded = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wren   = 1'b0;
                prev_loaded = 1'b0;
            end else begin
                if (o_imem_wren) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write addr=%0d data=%h expected no write",
                                 o_imem_address, o_imem_write_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_imem_address !== e.a || o_imem_write_data !== e.d) begin
                            errors++;
                            $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h",
                                     o_imem_address, o_imem_write_data, e.a, e.d);
                        end
                    end
                    check("strobe_single_cycle", {31'd0, prev_wren}, 32'd0);
                end
                if (o_loaded && !prev_loaded)
                    check("loaded_after_final_strobe", {31'd0, prev_wren}, {31'd0, exp_final_wren});
                prev_wren   = o_imem_wren;
                prev_loaded = o_loaded;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!o_rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
    endtask

    function automatic int pick_gap(input int gmode);
        if (gmode == 0) return 0;
        if (gmode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic load_prog(input int cnt, input int gmode);
        logic [31:0] hw;
        logic        err;
        wr_t         w;
        int          t;
        err            = (cnt > DEPTH);
        exp_final_wren = (cnt > 0) && !err;
        if (!err) begin
            for (int i = 0; i < cnt; i++) begin
                w.a = AW'(i);
                w.d = prog_words[i];
                exp_q.push_back(w);
            end
        end
        hw = 32'(cnt);
        for (int k = 0; k < 4; k++) send_byte(hw[8*k +: 8], pick_gap(gmode));
        if (!err) begin
            for (int i = 0; i < cnt; i++)
                for (int k = 0; k < 4; k++) send_byte(prog_words[i][8*k +: 8], pick_gap(gmode));
        end
        @(negedge clk);
        rx_valid = 1'b0;
        t = 0;
        while (!(o_loaded || o_load_error) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("loaded", {31'd0, o_loaded}, {31'd0, !err});
        check("load_error", {31'd0, o_load_error}, {31'd0, err});
        check("rx_ready_after_load", {31'd0, o_rx_ready}, 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        // Extra bytes offered in DONE/ERROR must stay upstream.
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rx_ready_held_low", {31'd0, o_rx_ready}, 32'd0);
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        #1;
        check("rx_ready_during_reload", {31'd0, o_rx_ready}, 32'd0);
        @(negedge clk);
        reload   = 1'b0;
        rx_valid = 1'b0;
        check("loaded_cleared", {31'd0, o_loaded}, 32'd0);
        check("error_cleared", {31'd0, o_load_error}, 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_rx_ready", {31'd0, o_rx_ready}, 32'd0);
        check("rst_wren", {31'd0, o_imem_wren}, 32'd0);
        check("rst_address", 32'(o_imem_address), 32'd0);
        check("rst_write_data", o_imem_write_data, 32'd0);
        check("rst_loaded", {31'd0, o_loaded}, 32'd0);
        check("rst_load_error", {31'd0, o_load_error}, 32'd0);
    endtask

    initial begin : driver
        int cnt;
        checks         = 0;
        errors         = 0;
        exp_final_wren = 1'b0;
        rst            = 1'b1;
        reload         = 1'b0;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rx_ready_after_rst", {31'd0, o_rx_ready}, 32'd1);

        // Nominal back-to-back load, then the same stream with rx_valid toggling.
        prog_words[0] = 32'h00100093;
        prog_words[1] = 32'h00200113;
        load_prog(2, 0);
        do_reload();
        load_prog(2, 1);

        // Boundaries: empty program, full memory, one past capacity.
        do_reload();
        load_prog(0, 0);
        do_reload();
        for (int i = 0; i < DEPTH; i++) prog_words[i] = $urandom;
        load_prog(DEPTH, 2);
        do_reload();
        load_prog(DEPTH + 1, 0);

        // Reload arriving with the 3rd payload byte aborts the partial word.
        do_reload();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        do_reload();
        prog_words[0] = 32'hDEADBEEF;
        load_prog(1, 0);

        // Asynchronous reset between edges after two payload bytes.
        do_reload();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rx_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        check("rst_no_strobe", {31'd0, o_imem_wren}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prog_words[0] = $urandom;
        prog_words[1] = $urandom;
        load_prog(2, 2);

        // Randomized programs, including occasional over-capacity headers.
        for (int p = 0; p < 8; p++) begin
            do_reload();
            cnt = int'($urandom_range(0, DEPTH + 1));
            for (int i = 0; i < DEPTH; i++) prog_words[i] = $urandom;
            load_prog(cnt, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
